// File: rtl/riscv_dtm_tap.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | riscv_dtm_tap: RISC-V JTAG DTM with IEEE 1149.1 TAP (IDCODE/DTMCS/DMI)  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module riscv_dtm_tap #(
  parameter int unsigned ABITS       = 7,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int unsigned IDLE_CYCLES = 1,
  parameter int unsigned IR_WIDTH    = 5
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             tms_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic             tdo_oe_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_op_i
);

  localparam int unsigned       DRW       = ABITS + 34;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);
  localparam logic [2:0]        C_IDLE    = 3'(IDLE_CYCLES);
  localparam logic [5:0]        C_ABITS   = 6'(ABITS);

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
    TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_e;

  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_e;
  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} sel_e;

  tap_e                tap_q, tap_d;
  dmi_e                dmi_q, dmi_d;
  sel_e                sel;
  logic [IR_WIDTH-1:0] ir_q, ir_sh_q;
  logic [DRW-1:0]      dr_q, dr_shift_d, dr_cap_d;
  logic [1:0]          sticky_q, sticky_d;
  logic [ABITS-1:0]    req_addr_q, req_addr_d;
  logic [31:0]         req_data_q, req_data_d, resp_data_q, resp_data_d;
  logic [1:0]          req_op_q, req_op_d;
  logic                tdo_q, tdo_oe_q;
  logic                dmi_busy, resp_fire;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) tap_q <= TAP_TLR;
    else        tap_q <= tap_d;
  end

  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TAP_TLR:      tap_d = tms_i ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      tap_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   tap_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   tap_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: tap_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: tap_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: tap_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: tap_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   tap_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   tap_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   tap_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: tap_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: tap_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: tap_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: tap_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   tap_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      default:      tap_d = TAP_TLR;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_q    <= IR_IDCODE;
      ir_sh_q <= '0;
    end else begin
      case (tap_q)
        TAP_TLR:      ir_q    <= IR_IDCODE;
        TAP_CAP_IR:   ir_sh_q <= IR_WIDTH'(1);
        TAP_SHIFT_IR: ir_sh_q <= {tdi_i, ir_sh_q[IR_WIDTH-1:1]};
        TAP_UPD_IR:   ir_q    <= ir_sh_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (ir_q == IR_IDCODE)     sel = SEL_IDCODE;
    else if (ir_q == IR_DTMCS) sel = SEL_DTMCS;
    else if (ir_q == IR_DMI)   sel = SEL_DMI;
    else                       sel = SEL_BYPASS;
  end

  assign dmi_busy  = (dmi_q != DMI_IDLE);
  assign resp_fire = (dmi_q == DMI_WAIT) && resp_valid_i;

  // A response landing on the capture edge supplies the captured data.
  always_comb begin
    dr_cap_d = '0;
    case (sel)
      SEL_IDCODE: dr_cap_d = DRW'(IDCODE_VAL);
      SEL_DTMCS:  dr_cap_d = DRW'({17'd0, C_IDLE, sticky_q, C_ABITS, 4'd1});
      SEL_DMI:    dr_cap_d = {req_addr_q, (resp_fire ? resp_data_i : resp_data_q),
                              (dmi_busy ? 2'd3 : sticky_q)};
      default:    dr_cap_d = '0;
    endcase
  end

  always_comb begin
    dr_shift_d = dr_q >> 1;
    case (sel)
      SEL_DMI:    dr_shift_d[DRW-1] = tdi_i;
      SEL_BYPASS: dr_shift_d[0]     = tdi_i;
      default:    dr_shift_d[31]    = tdi_i;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                     dr_q <= '0;
    else if (tap_q == TAP_CAP_DR)   dr_q <= dr_cap_d;
    else if (tap_q == TAP_SHIFT_DR) dr_q <= dr_shift_d;
  end

  always_comb begin
    dmi_d       = dmi_q;
    sticky_d    = sticky_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    resp_data_d = resp_data_q;
    case (dmi_q)
      DMI_REQ: if (req_ready_i) dmi_d = DMI_WAIT;
      DMI_WAIT: begin
        if (resp_valid_i) begin
          resp_data_d = resp_data_i;
          if (resp_op_i != 2'd0 && sticky_q == 2'd0) sticky_d = 2'd2;
          dmi_d = DMI_IDLE;
        end
      end
      default: ;
    endcase
    // Busy indication outranks a same-edge response error.
    if (tap_q == TAP_CAP_DR && sel == SEL_DMI && dmi_busy && sticky_q == 2'd0)
      sticky_d = 2'd3;
    if (tap_q == TAP_UPD_DR && sel == SEL_DMI && sticky_q == 2'd0) begin
      if (dmi_busy) begin
        sticky_d = 2'd3;
      end else if (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2) begin
        req_op_d   = dr_q[1:0];
        req_data_d = dr_q[33:2];
        req_addr_d = dr_q[DRW-1:34];
        dmi_d      = DMI_REQ;
      end
    end
    if (tap_q == TAP_UPD_DR && sel == SEL_DTMCS && (dr_q[16] || dr_q[17])) begin
      sticky_d = 2'd0;
      if (dr_q[17]) dmi_d = DMI_IDLE;
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      dmi_q       <= DMI_IDLE;
      sticky_q    <= 2'd0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= 2'd0;
      resp_data_q <= '0;
    end else begin
      dmi_q       <= dmi_d;
      sticky_q    <= sticky_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= (tap_q == TAP_SHIFT_IR) || (tap_q == TAP_SHIFT_DR);
      if (tap_q == TAP_SHIFT_IR)      tdo_q <= ir_sh_q[0];
      else if (tap_q == TAP_SHIFT_DR) tdo_q <= dr_q[0];
      else                            tdo_q <= 1'b0;
    end
  end

  assign tdo_o        = tdo_q;
  assign tdo_oe_o     = tdo_oe_q;
  assign req_valid_o  = (dmi_q == DMI_REQ);
  assign resp_ready_o = (dmi_q == DMI_WAIT);
  assign req_addr_o   = req_addr_q;
  assign req_data_o   = req_data_q;
  assign req_op_o     = req_op_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dtm_tap.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_riscv_dtm_tap: directed self-checking bench for riscv_dtm_tap       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_riscv_dtm_tap;

  logic        tck_i = 1'b0;
  logic        trst_i, tms_i, tdi_i, tdo_o, tdo_oe_o;
  logic        req_valid_o, req_ready_i, resp_valid_i, resp_ready_o;
  logic [6:0]  req_addr_o;
  logic [31:0] req_data_o, resp_data_i;
  logic [1:0]  req_op_o, resp_op_i;
  int          checks = 0;
  int          errors = 0;

  riscv_dtm_tap dut (
    .tck_i(tck_i), .trst_i(trst_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_data_i(resp_data_i), .resp_op_i(resp_op_i)
  );

  always #5 tck_i = ~tck_i;

  // One TCK: drive, clock, then sample after the falling edge.
  task automatic step(input logic tms, input logic tdi, output logic t, output logic o);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
    t = tdo_o;
    o = tdo_oe_o;
  endtask

  task automatic idle();
    logic t, o;
    step(1'b0, 1'b0, t, o);
  endtask

  // Run-Test/Idle -> DR scan of len bits -> Run-Test/Idle.
  task automatic scan_dr(input logic [63:0] din, input int len,
                         output logic [63:0] dout, output logic oe_ok);
    logic t, o;
    dout  = '0;
    oe_ok = 1'b1;
    step(1'b1, 1'b0, t, o); if (o) oe_ok = 1'b0;
    step(1'b0, 1'b0, t, o); if (o) oe_ok = 1'b0;
    step(1'b0, 1'b0, t, o);
    for (int i = 0; i < len; i++) begin
      dout[i] = t;
      if (!o) oe_ok = 1'b0;
      step(i == len - 1, din[i], t, o);
    end
    if (o) oe_ok = 1'b0;
    step(1'b1, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
  endtask

  task automatic scan_ir(input logic [4:0] ir);
    logic t, o;
    step(1'b1, 1'b0, t, o);
    step(1'b1, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
    for (int i = 0; i < 5; i++) step(i == 4, ir[i], t, o);
    step(1'b1, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
  endtask

  function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return 64'({a, d, op});
  endfunction

  task automatic test_reset();
    logic [63:0] d;
    logic ok;
    trst_i = 1'b1; tms_i = 1'b1; tdi_i = 1'b0;
    req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0; resp_op_i = '0;
    repeat (3) @(negedge tck_i);
    #1;
    checks++;
    if ({req_valid_o, resp_ready_o, tdo_o, tdo_oe_o, req_op_o, req_addr_o, req_data_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got v%b r%b tdo%b oe%b op%h a%h d%h exp all 0",
        req_valid_o, resp_ready_o, tdo_o, tdo_oe_o, req_op_o, req_addr_o, req_data_o);
    end
    trst_i = 1'b0;
    idle();
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h1000_0001) begin
      errors++; $display("FAIL idcode got %h exp %h", d[31:0], 32'h1000_0001);
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL idcode_oe got %b exp 1", ok); end
  endtask

  task automatic test_dtmcs();
    logic [63:0] d;
    logic ok;
    scan_ir(5'h10);
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h0000_1071) begin
      errors++; $display("FAIL dtmcs got %h exp %h", d[31:0], 32'h0000_1071);
    end
  endtask

  task automatic test_dmi_write();
    logic [63:0] d;
    logic ok;
    scan_ir(5'h11);
    scan_dr(dmi(7'h10, 32'hDEAD_BEEF, 2'd2), 41, d, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_valid_o, req_addr_o, req_data_o, req_op_o} !== {1'b1, 7'h10, 32'hDEAD_BEEF, 2'd2}) begin
        errors++; $display("FAIL write_hold[%0d] got v%b a%h d%h op%h exp v1 a10 ddeadbeef op2",
          i, req_valid_o, req_addr_o, req_data_o, req_op_o);
      end
      idle();
    end
    req_ready_i = 1'b1;
    idle();
    req_ready_i = 1'b0;
    checks++;
    if ({req_valid_o, resp_ready_o} !== 2'b01) begin
      errors++; $display("FAIL write_wait got v%b r%b exp v0 r1", req_valid_o, resp_ready_o);
    end
    resp_valid_i = 1'b1; resp_data_i = 32'h0; resp_op_i = 2'd0;
    idle();
    resp_valid_i = 1'b0;
    checks++;
    if (resp_ready_o !== 1'b0) begin errors++; $display("FAIL write_done got r%b exp 0", resp_ready_o); end
    scan_dr(64'd0, 41, d, ok);
    checks++;
    if (d[1:0] !== 2'd0 || d[40:34] !== 7'h10) begin
      errors++; $display("FAIL write_status got st%0d a%h exp st0 a10", d[1:0], d[40:34]);
    end
  endtask

  task automatic test_dmi_read();
    logic [63:0] d;
    logic ok;
    scan_dr(dmi(7'h04, 32'h0, 2'd1), 41, d, ok);
    checks++;
    if ({req_valid_o, req_addr_o, req_op_o} !== {1'b1, 7'h04, 2'd1}) begin
      errors++; $display("FAIL read_req got v%b a%h op%h exp v1 a04 op1", req_valid_o, req_addr_o, req_op_o);
    end
    req_ready_i = 1'b1; idle(); req_ready_i = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = 32'h1234_5678; resp_op_i = 2'd0;
    idle();
    resp_valid_i = 1'b0;
    scan_dr(64'd0, 41, d, ok);
    checks++;
    if (d[40:0] !== 41'({7'h04, 32'h1234_5678, 2'd0})) begin
      errors++; $display("FAIL read_capture got %h exp %h", d[40:0], 41'({7'h04, 32'h1234_5678, 2'd0}));
    end
  endtask

  task automatic test_busy_sticky();
    logic [63:0] d;
    logic ok;
    scan_dr(dmi(7'h08, 32'h0, 2'd1), 41, d, ok);
    req_ready_i = 1'b1; idle(); req_ready_i = 1'b0;
    scan_dr(64'd0, 41, d, ok);
    checks++;
    if (d[1:0] !== 2'd3) begin errors++; $display("FAIL busy_capture got %0d exp 3", d[1:0]); end
    resp_valid_i = 1'b1; resp_data_i = 32'h55; resp_op_i = 2'd0;
    idle();
    resp_valid_i = 1'b0;
    scan_ir(5'h10);
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h0000_1C71) begin errors++; $display("FAIL dmistat3 got %h exp %h", d[31:0], 32'h1C71); end
    scan_ir(5'h11);
    scan_dr(dmi(7'h0C, 32'h0, 2'd1), 41, d, ok);
    checks++;
    if (d[1:0] !== 2'd3 || req_valid_o !== 1'b0) begin
      errors++; $display("FAIL sticky_ignore got st%0d v%b exp st3 v0", d[1:0], req_valid_o);
    end
    scan_ir(5'h10);
    scan_dr(64'h1_0000, 32, d, ok);
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h0000_1071) begin errors++; $display("FAIL dmireset got %h exp %h", d[31:0], 32'h1071); end
    scan_ir(5'h11);
    scan_dr(dmi(7'h0C, 32'h0, 2'd1), 41, d, ok);
    checks++;
    if (d[1:0] !== 2'd0 || {req_valid_o, req_addr_o} !== {1'b1, 7'h0C}) begin
      errors++; $display("FAIL after_reset got st%0d v%b a%h exp st0 v1 a0c", d[1:0], req_valid_o, req_addr_o);
    end
    req_ready_i = 1'b1; idle(); req_ready_i = 1'b0;
    resp_valid_i = 1'b1; resp_data_i = 32'hA5A5_A5A5; resp_op_i = 2'd3;
    idle();
    resp_valid_i = 1'b0;
    scan_dr(64'd0, 41, d, ok);
    checks++;
    if (d[33:0] !== {32'hA5A5_A5A5, 2'd2}) begin
      errors++; $display("FAIL resp_error got %h exp %h", d[33:0], {32'hA5A5_A5A5, 2'd2});
    end
    scan_ir(5'h10);
    scan_dr(64'h1_0000, 32, d, ok);
  endtask

  task automatic test_hardreset();
    logic [63:0] d;
    logic ok, t, o;
    scan_ir(5'h11);
    scan_dr(dmi(7'h1F, 32'h1, 2'd2), 41, d, ok);
    scan_ir(5'h10);
    checks++;
    if (req_valid_o !== 1'b1) begin errors++; $display("FAIL hr_pending got %b exp 1", req_valid_o); end
    scan_dr(64'h2_0000, 32, d, ok);
    checks++;
    if ({req_valid_o, resp_ready_o} !== 2'b00) begin
      errors++; $display("FAIL hr_drop got v%b r%b exp v0 r0", req_valid_o, resp_ready_o);
    end
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h0000_1071) begin errors++; $display("FAIL hr_dtmcs got %h exp %h", d[31:0], 32'h1071); end
    scan_ir(5'h11);
    scan_dr(dmi(7'h02, 32'h77, 2'd2), 41, d, ok);
    step(1'b1, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
    step(1'b0, 1'b0, t, o);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, t, o);
    checks++;
    if ({req_valid_o, o} !== 2'b11) begin
      errors++; $display("FAIL pre_trst got v%b oe%b exp v1 oe1", req_valid_o, o);
    end
    #2 trst_i = 1'b1;
    #1;
    checks++;
    if ({req_valid_o, resp_ready_o, tdo_o, tdo_oe_o, req_op_o, req_addr_o, req_data_o} !== '0) begin
      errors++; $display("FAIL trst_outputs got v%b r%b tdo%b oe%b op%h a%h d%h exp all 0",
        req_valid_o, resp_ready_o, tdo_o, tdo_oe_o, req_op_o, req_addr_o, req_data_o);
    end
    @(negedge tck_i);
    #1 trst_i = 1'b0;
    idle();
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL trst_ir got %h exp %h", d[31:0], 32'h1000_0001); end
  endtask

  task automatic test_bypass_tms_reset();
    logic [63:0] d;
    logic ok, t, o;
    scan_ir(5'h05);
    scan_dr(64'hB5, 8, d, ok);
    checks++;
    if (d[7:0] !== 8'h6A) begin errors++; $display("FAIL bypass got %h exp %h", d[7:0], 8'h6A); end
    scan_ir(5'h10);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t, o);
    idle();
    scan_dr(64'd0, 32, d, ok);
    checks++;
    if (d[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL tms_reset got %h exp %h", d[31:0], 32'h1000_0001); end
  endtask

  initial begin
    test_reset();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_busy_sticky();
    test_hardreset();
    test_bypass_tms_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
